// File: rtl/tspi_target_shift_reg.sv
// tspi_target_shift_reg: target-side TSPI endpoint between the pad ring and the register file.
// Latency: req_valid_o rises the cycle after the last frame bit; the reply start bit follows the response latch by one cycle.
// Backpressure: req_valid_o and its address/we/wdata are held until req_ready_i; mosi_i is ignored until the target is back in IDLE.
//
// Frame on mosi_i: start(0), rw(1 = write), ADDR_W address bits MSB first,
// then DATA_W write-data bits MSB first (writes only).
// Reply on miso_o: one low start bit, then DATA_W response bits MSB first.
// Optional macro TSPI_TARGET_PARITY_EN: adds an even-parity bit after write data
// (a mismatch suppresses the request and forces an error reply) and a trailing
// even-parity bit after every reply.
//
// Ports:
//   clk_i, rst_i            clock; synchronous active-high reset
//   mosi_i / miso_o         serial in from host / registered serial out to host (both idle high)
//   req_valid_o/req_ready_i register-access handshake; req_we_o, req_addr_o, req_wdata_o payload
//   rsp_valid_i/rsp_rdata_i response strobe and read data
//   busy_o                  high whenever not IDLE
//   err_o                   one-cycle pulse on timeout or write-parity error
module tspi_target_shift_reg #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_wdata_o,
  input  logic              rsp_valid_i,
  input  logic [DATA_W-1:0] rsp_rdata_i,
  output logic              busy_o,
  output logic              err_o
);

`ifdef TSPI_TARGET_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Bit counter covers the rw+address phase and the data phases.
  localparam int CNT_MAX = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TCNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_WPAR,
    S_REQ,
    S_WAIT,
    S_START,
    S_SEND,
    S_RPAR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CNT_W-1:0]    r_cnt;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_shift;
  logic                r_rpar;
  logic                r_miso;
  logic                r_err;

  logic                w_last_addr;
  logic                w_last_data;
  logic                w_timeout;
  logic                w_wpar_ok;

  // CMD: count 0 is the rw sample, counts 1..ADDR_W are address bits.
  assign w_last_addr = (r_cnt == CNT_W'(ADDR_W));
  assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));
  // r_tcnt counts completed WAIT cycles; firing at TIMEOUT_CYC-1 bounds the
  // stay in WAIT to exactly TIMEOUT_CYC cycles.
  assign w_timeout   = (TIMEOUT_CYC != 0) && (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));
  // Even parity: the parity bit equals the XOR of the payload.
  assign w_wpar_ok   = (mosi_i == (^r_wdata));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!mosi_i) w_state_nxt = S_CMD;
      S_CMD:   if (w_last_addr) w_state_nxt = r_rw ? S_WDATA : S_REQ;
      S_WDATA: if (w_last_data) w_state_nxt = PAR_EN ? S_WPAR : S_REQ;
      S_WPAR:  w_state_nxt = w_wpar_ok ? S_REQ : S_START;
      S_REQ:   if (req_ready_i) w_state_nxt = S_WAIT;
      S_WAIT:  if (rsp_valid_i || w_timeout) w_state_nxt = S_START;
      S_START: w_state_nxt = S_SEND;
      S_SEND:  if (w_last_data) w_state_nxt = PAR_EN ? S_RPAR : S_IDLE;
      S_RPAR:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: frame capture, response latch and reply serialiser.
  // r_miso is loaded one edge ahead so miso_o lines up with the state it belongs to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_shift <= '0;
      r_rpar  <= 1'b0;
      r_miso  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!mosi_i) begin
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;   // reads present zero write data
          end
        end
        S_CMD: begin
          if (r_cnt == '0) begin
            r_rw <= mosi_i;
          end else begin
            r_addr <= (r_addr << 1) | ADDR_W'(mosi_i);
          end
          r_cnt <= w_last_addr ? '0 : r_cnt + CNT_W'(1);
        end
        S_WDATA: begin
          r_wdata <= (r_wdata << 1) | DATA_W'(mosi_i);
          r_cnt   <= w_last_data ? '0 : r_cnt + CNT_W'(1);
        end
        S_WPAR: begin
          if (!w_wpar_ok) begin
            r_shift <= '1;
            r_rpar  <= ^{DATA_W{1'b1}};
            r_err   <= 1'b1;
            r_miso  <= 1'b0;
          end
        end
        S_REQ: begin
          if (req_ready_i) r_tcnt <= '0;
        end
        S_WAIT: begin
          // A response arriving on the timeout cycle wins: no error pulse.
          if (rsp_valid_i) begin
            r_shift <= r_rw ? '0 : rsp_rdata_i;
            r_rpar  <= r_rw ? 1'b0 : ^rsp_rdata_i;
            r_miso  <= 1'b0;
          end else if (w_timeout) begin
            r_shift <= '1;
            r_rpar  <= ^{DATA_W{1'b1}};
            r_err   <= 1'b1;
            r_miso  <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
        end
        S_START: begin
          r_miso  <= r_shift[DATA_W-1];
          r_shift <= r_shift << 1;
          r_cnt   <= '0;
        end
        S_SEND: begin
          if (w_last_data) begin
            r_miso <= PAR_EN ? r_rpar : 1'b1;
          end else begin
            r_miso  <= r_shift[DATA_W-1];
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        S_RPAR: begin
          r_miso <= 1'b1;
        end
        default: begin
          r_miso <= 1'b1;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    req_valid_o = (r_state == S_REQ);
    busy_o      = (r_state != S_IDLE);
    req_we_o    = r_rw;
    req_addr_o  = r_addr;
    req_wdata_o = r_wdata;
    miso_o      = r_miso;
    err_o       = r_err;
  end

endmodule

// File: tb/tb_tspi_target_shift_reg.sv
`timescale 1ns/1ps
module tb_tspi_target_shift_reg;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              mosi;
  logic              miso;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

`ifdef TSPI_TARGET_PARITY_EN
  logic par_flip = 1'b0;
  logic rpar_got;
`endif

  tspi_target_shift_reg #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mosi_i     (mosi),
    .miso_o     (miso),
    .req_valid_o(req_valid),
    .req_ready_i(req_ready),
    .req_we_o   (req_we),
    .req_addr_o (req_addr),
    .req_wdata_o(req_wdata),
    .rsp_valid_i(rsp_valid),
    .rsp_rdata_i(rsp_rdata),
    .busy_o     (busy),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are observed on the falling edge.
  // Called at a falling edge; returns at the falling edge after the last bit.
  task automatic send_frame(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    mosi = 1'b0; @(negedge clk);
    mosi = rw;   @(negedge clk);
    for (int i = ADDR_W - 1; i >= 0; i--) begin mosi = addr[i]; @(negedge clk); end
    if (rw) begin
      for (int i = DATA_W - 1; i >= 0; i--) begin mosi = data[i]; @(negedge clk); end
`ifdef TSPI_TARGET_PARITY_EN
      mosi = (^data) ^ par_flip; @(negedge clk);
`endif
    end
    mosi = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (req_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Captures one reply; returns at the falling edge showing the bit after it.
  task automatic collect_reply(output logic [DATA_W-1:0] data, output bit ok,
                               output int waited, output int errs, output logic stop);
    ok = 1'b0; waited = 0; errs = 0; data = '0; stop = 1'bx;
    for (int n = 0; n < 200; n++) begin
      if (err === 1'b1) errs++;
      if (miso === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk); waited++;
    end
    if (ok) begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        @(negedge clk); data[i] = miso; if (err === 1'b1) errs++;
      end
`ifdef TSPI_TARGET_PARITY_EN
      @(negedge clk); rpar_got = miso; if (err === 1'b1) errs++;
`endif
      @(negedge clk); stop = miso; if (err === 1'b1) errs++;
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rdata,
                         input int gap, input string tag);
    req_t er; rsp_t es; logic [DATA_W-1:0] got; bit ok; int waited, errs; logic stop;
    exp_req_q.push_back('{we: 1'b0, addr: addr, wdata: '0});
    req_ready = 1'b1;
    send_frame(1'b0, addr, '0);
    checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL %s_req_latency req_valid=%0b exp=1", tag, req_valid); end
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_req_wait req_valid never rose exp=1", tag); end
    er = exp_req_q.pop_front();
    checks++; if ({req_we, req_addr, req_wdata} !== er) begin failures++; $display("FAIL %s_req_fields got=%h exp=%h", tag, {req_we, req_addr, req_wdata}, er); end
    @(negedge clk); req_ready = 1'b0;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL %s_req_drop req_valid=%0b exp=0", tag, req_valid); end
    repeat (gap) @(negedge clk);
    rsp_rdata = rdata; rsp_valid = 1'b1;
    exp_rsp_q.push_back('{data: rdata, err: 1'b0});
    @(negedge clk); rsp_valid = 1'b0;
    collect_reply(got, ok, waited, errs, stop);
    es = exp_rsp_q.pop_front();
    checks++; if (!ok) begin failures++; $display("FAIL %s_reply_start no start bit within bound exp=start", tag); end
    checks++; if (got !== es.data) begin failures++; $display("FAIL %s_reply_data got=%h exp=%h", tag, got, es.data); end
    checks++; if (errs != 0) begin failures++; $display("FAIL %s_err pulses=%0d exp=0", tag, errs); end
`ifdef TSPI_TARGET_PARITY_EN
    checks++; if (rpar_got !== ^rdata) begin failures++; $display("FAIL %s_reply_par got=%0b exp=%0b", tag, rpar_got, ^rdata); end
`endif
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL %s_reply_stop miso=%0b exp=1", tag, stop); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_idle busy=%0b exp=0", tag, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1; mosi = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL reset_miso got=%0b exp=1", miso); end
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", req_valid); end
    checks++; if (req_we !== 1'b0) begin failures++; $display("FAIL reset_req_we got=%0b exp=0", req_we); end
    checks++; if (req_addr !== '0) begin failures++; $display("FAIL reset_req_addr got=%h exp=0", req_addr); end
    checks++; if (req_wdata !== '0) begin failures++; $display("FAIL reset_req_wdata got=%h exp=0", req_wdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_mosi_high busy=%0b exp=0", busy); end
  endtask

  task automatic test_read;
    do_read(7'h15, 32'hA5A5_0F0F, 2, "read");
  endtask

  task automatic test_write;
    req_t er; rsp_t es; logic [DATA_W-1:0] got; bit ok; int waited, errs, held; logic stop;
    exp_req_q.push_back('{we: 1'b1, addr: 7'h02, wdata: 32'hDEAD_BEEF});
    req_ready = 1'b0;
    send_frame(1'b1, 7'h02, 32'hDEAD_BEEF);
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL write_req_wait req_valid never rose exp=1"); end
    er = exp_req_q.pop_front();
    checks++; if ({req_we, req_addr, req_wdata} !== er) begin failures++; $display("FAIL write_req_fields got=%h exp=%h", {req_we, req_addr, req_wdata}, er); end
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (req_valid === 1'b1 && {req_we, req_addr, req_wdata} === er) held++;
      if (i == 4) req_ready = 1'b1;
    end
    @(negedge clk); req_ready = 1'b0;
    checks++; if (held != 5) begin failures++; $display("FAIL write_hold stable_valid_cycles=%0d exp=5", held); end
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL write_req_drop req_valid=%0b exp=0", req_valid); end
    rsp_rdata = 32'h1234_5678; rsp_valid = 1'b1;
    exp_rsp_q.push_back('{data: '0, err: 1'b0});
    @(negedge clk); rsp_valid = 1'b0;
    collect_reply(got, ok, waited, errs, stop);
    es = exp_rsp_q.pop_front();
    checks++; if (!ok) begin failures++; $display("FAIL write_reply_start no start bit exp=start"); end
    checks++; if (got !== es.data) begin failures++; $display("FAIL write_reply_data got=%h exp=%h", got, es.data); end
    checks++; if (errs != 0) begin failures++; $display("FAIL write_err pulses=%0d exp=0", errs); end
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL write_reply_stop miso=%0b exp=1", stop); end
  endtask

  task automatic test_timeout;
    req_t er; rsp_t es; logic [DATA_W-1:0] got; bit ok; int waited, errs; logic stop;
    exp_req_q.push_back('{we: 1'b0, addr: 7'h33, wdata: '0});
    req_ready = 1'b1;
    send_frame(1'b0, 7'h33, '0);
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL tmo_req_wait req_valid never rose exp=1"); end
    er = exp_req_q.pop_front();
    checks++; if ({req_we, req_addr, req_wdata} !== er) begin failures++; $display("FAIL tmo_req_fields got=%h exp=%h", {req_we, req_addr, req_wdata}, er); end
    @(negedge clk); req_ready = 1'b0;
    exp_rsp_q.push_back('{data: '1, err: 1'b1});
    collect_reply(got, ok, waited, errs, stop);
    es = exp_rsp_q.pop_front();
    checks++; if (!ok) begin failures++; $display("FAIL tmo_reply_start no start bit exp=start"); end
    checks++; if (waited != TIMEOUT_CYC) begin failures++; $display("FAIL tmo_wait_cycles got=%0d exp=%0d", waited, TIMEOUT_CYC); end
    checks++; if (got !== es.data) begin failures++; $display("FAIL tmo_reply_data got=%h exp=%h", got, es.data); end
    checks++; if (errs != 1) begin failures++; $display("FAIL tmo_err pulses=%0d exp=1", errs); end
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL tmo_reply_stop miso=%0b exp=1", stop); end
  endtask

  task automatic test_reset_mid_cmd;
    logic [3:0] bits; int seen;
    bits = 4'b1011;
    mosi = 1'b0; @(negedge clk);
    mosi = 1'b0; @(negedge clk);
    for (int i = 3; i >= 0; i--) begin mosi = bits[i]; @(negedge clk); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%0b exp=1", busy); end
    rst = 1'b1; mosi = 1'b1;
    @(negedge clk);
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL midrst_miso got=%0b exp=1", miso); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL midrst_req_valid got=%0b exp=0", req_valid); end
    rst = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (req_valid !== 1'b0 || busy !== 1'b0) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrst_quiet active_cycles=%0d exp=0", seen); end
    do_read(7'h5A, 32'h1357_9BDF, 1, "post_rst");
  endtask

  task automatic test_spurious;
    rsp_t es; logic [DATA_W-1:0] got; bit ok; int waited, errs, bad; logic stop; req_t er;
    rsp_rdata = 32'hBAD0_BAD0; rsp_valid = 1'b1; bad = 0;
    repeat (3) begin @(negedge clk); if (busy !== 1'b0 || miso !== 1'b1) bad++; end
    rsp_valid = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL spur_idle active_cycles=%0d exp=0", bad); end
    exp_req_q.push_back('{we: 1'b0, addr: 7'h4C, wdata: '0});
    req_ready = 1'b0;
    send_frame(1'b0, 7'h4C, '0);
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL spur_req_wait req_valid never rose exp=1"); end
    er = exp_req_q.pop_front();
    checks++; if ({req_we, req_addr, req_wdata} !== er) begin failures++; $display("FAIL spur_req_fields got=%h exp=%h", {req_we, req_addr, req_wdata}, er); end
    rsp_valid = 1'b1; bad = 0;
    repeat (2) begin @(negedge clk); if (req_valid !== 1'b1 || miso !== 1'b1) bad++; end
    rsp_valid = 1'b0; req_ready = 1'b1;
    checks++; if (bad != 0) begin failures++; $display("FAIL spur_req_hold bad_cycles=%0d exp=0", bad); end
    @(negedge clk); req_ready = 1'b0;
    repeat (2) @(negedge clk);
    rsp_rdata = 32'h0123_4567; rsp_valid = 1'b1;
    exp_rsp_q.push_back('{data: 32'h0123_4567, err: 1'b0});
    @(negedge clk); rsp_valid = 1'b0;
    collect_reply(got, ok, waited, errs, stop);
    es = exp_rsp_q.pop_front();
    checks++; if (got !== es.data) begin failures++; $display("FAIL spur_reply_data got=%h exp=%h", got, es.data); end
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL spur_reply_stop miso=%0b exp=1", stop); end
  endtask

  // The second frame's start bit is driven at the falling edge where the first
  // reply's stop level is observed, i.e. during the first IDLE cycle.
  task automatic test_back_to_back;
    do_read(7'h21, 32'hCAFE_F00D, 1, "b2b_first");
    do_read(7'h6E, 32'h8000_0001, 3, "b2b_second");
  endtask

`ifdef TSPI_TARGET_PARITY_EN
  task automatic test_parity;
    rsp_t es; logic [DATA_W-1:0] got; bit ok; int waited, errs; logic stop;
    req_ready = 1'b1; par_flip = 1'b1;
    exp_rsp_q.push_back('{data: '1, err: 1'b1});
    send_frame(1'b1, 7'h02, 32'h0000_0001);
    par_flip = 1'b0;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL par_no_req req_valid=%0b exp=0", req_valid); end
    collect_reply(got, ok, waited, errs, stop);
    req_ready = 1'b0;
    es = exp_rsp_q.pop_front();
    checks++; if (waited != 0) begin failures++; $display("FAIL par_start_latency got=%0d exp=0", waited); end
    checks++; if (got !== es.data) begin failures++; $display("FAIL par_reply_data got=%h exp=%h", got, es.data); end
    checks++; if (errs != 1) begin failures++; $display("FAIL par_err pulses=%0d exp=1", errs); end
    checks++; if (rpar_got !== 1'b0) begin failures++; $display("FAIL par_reply_par got=%0b exp=0", rpar_got); end
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL par_reply_stop miso=%0b exp=1", stop); end
    do_read(7'h11, 32'h0000_0003, 2, "par_read");
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_reset_mid_cmd();
    test_spurious();
    test_back_to_back();
`ifdef TSPI_TARGET_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_req_q.size() != 0 || exp_rsp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain req_left=%0d rsp_left=%0d exp=0", exp_req_q.size(), exp_rsp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tspi_target_shift_reg.md
Name: tspi_target_shift_reg

Overview:
Target-side (device) endpoint of the TSPI serial link, the counterpart to the host shift register.
- Deserialises host frames arriving on mosi: start bit, R/W flag, address, and optional write data.
- Issues one request on a valid/ready register-access port and waits for the response.
- Serialises the reply on miso as a low start bit followed by the data word, MSB first.
- Sits between the pad ring and the target's register file.

Parameters:
ADDR_W, 7, address bits per command frame
DATA_W, 32, data bits per write payload and per response
TIMEOUT_CYC, 255, max clk_i cycles in WAIT_RSP before forced error reply (0 = no timeout)

Ports:
clk_i  in  1  TSPI clock, one clock; all logic on rising edge
rst_i  in  1  reset is synchronous and active-high
mosi_i  in  1  serial from host; idles high
miso_o  out  1  serial to host; idles high; registered
req_valid_o  out  1  register access request
req_ready_i  in  1  register file accepts request
req_we_o  out  1  1 = write, 0 = read
req_addr_o  out  ADDR_W  access address
req_wdata_o  out  DATA_W  write data (0 on reads)
rsp_valid_i  in  1  response available (single-cycle pulse allowed)
rsp_rdata_i  in  DATA_W  read data; ignored for writes
busy_o  out  1  high in every state except IDLE
err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values: miso_o=1, req_valid_o=0, req_we_o=0, req_addr_o=0, req_wdata_o=0, busy_o=0, err_o=0, state=IDLE, bit counter=0. Reset mid-frame aborts the frame and drops any pending request.
- Frame format on mosi, sampled each clk_i edge: start(0), rw(1 = write), ADDR_W address bits MSB first, then DATA_W data bits MSB first if rw=1. mosi is don't-care after the frame until the target returns to IDLE.
- IDLE: mosi_i=0 -> CMD, counter cleared. mosi_i=1 -> stay.
- CMD: first sample is rw; next ADDR_W samples shift into the address (MSB first).
  - After the last address bit: rw=1 -> WDATA; rw=0 -> REQ.
- WDATA: DATA_W samples shift into wdata; the last bit transitions to REQ.
- REQ: req_valid_o=1 from the cycle after the last frame bit. Address, we and wdata are stable while valid is high. Valid stays high until a cycle with req_ready_i=1; then -> WAIT_RSP.
  - req_ready_i is sampled only while valid is high.
- WAIT_RSP:
  - rsp_valid_i=1 -> latch the response (rsp_rdata_i for reads, 0 for writes), then -> START.
  - Timeout counter reaches TIMEOUT_CYC -> latch all-ones, pulse err_o, then -> START.
  - rsp_valid_i and timeout in the same cycle: the response wins and no err_o pulse is emitted.
  - rsp_valid_i in any other state is ignored.
- START: miso_o=0 for exactly one cycle, beginning the cycle after the latch. Then -> SEND.
- SEND: miso_o carries response bit DATA_W-1 down to 0, one per cycle. After bit 0 -> IDLE, and miso_o=1 in the following cycle.
- Total miso activity per reply: 1 + DATA_W cycles.
- Back-to-back: a start bit sampled in the cycle the target re-enters IDLE is accepted. Host start bits in any non-IDLE state are ignored.
- Counters: bit counter is wide enough for max(ADDR_W+1, DATA_W); timeout counter is clog2(TIMEOUT_CYC+1) bits. No wrap-around in either counter, since both saturate into a transition.

Optional Feature:
TSPI_TARGET_PARITY_EN
- Defined:
  - An even-parity bit over the DATA_W response bits is sent as one extra cycle after bit 0, before miso returns high.
  - Write frames carry one extra even-parity bit after the data. On mismatch, no request is issued, err_o pulses, and the reply is start bit + all-ones + parity.
- Undefined: no parity bits in either direction; behaviour exactly as above.

Test Plan:
- Read: frame 0,0,addr=7'h15, req_ready_i=1 immediately, rsp_valid_i after 3 cycles with 32'hA5A5_0F0F -> req_addr_o=7'h15, req_we_o=0; miso_o 0 then A5A50F0F MSB first, then 1.
- Write: frame 0,1,addr=7'h02, data 32'hDEAD_BEEF, req_ready_i low for 4 cycles -> req_valid_o held 5 cycles with stable wdata=DEADBEEF; reply start bit + 32 zeros.
- Timeout: TIMEOUT_CYC=8, read, rsp_valid_i never asserted -> err_o pulses once; reply start bit + 32'hFFFF_FFFF.
- Reset mid-CMD: rst_i high after 4 address bits -> next cycle miso_o=1, busy_o=0, no req_valid_o. A following full frame behaves normally.
- Spurious rsp_valid_i in IDLE or REQ is ignored. Back-to-back reads with a new start bit in the first IDLE cycle -> both served in order.
- Parity (macro on): write data 32'h0000_0001 with parity bit 0 -> no request, err_o pulse; read of 32'h3 -> trailing parity bit 0.
